uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that samples the asynchronous `rx` line at 16× oversampling, deframes start/data/optional-parity/stop bits, and produces one parallel word per frame. It sits directly upstream of the RX FIFO. `rx_done_tick` drives the FIFO `wr` input, and `dout` drives `w_data`. An internal baud-tick generator derives the oversampling strobe from `clk`.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, 5..9.
- `SB_TICK`, 16: oversampling ticks spent in the stop bit. 16 means 1 stop bit, 24 means 1.5, 32 means 2.
- `CLK_DIV`, 163: clk cycles per oversampling tick. 50 MHz / (16 × 19200) ≈ 163. Must be ≥ 2.
- `PARITY_EN`, 0: 1 means one parity bit follows the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN` = 0.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `rx`, input, 1: serial line, idle high, asynchronous to `clk`.
- `rx_done_tick`, output, 1: one-cycle pulse; a frame has completed.
- `dout`, output, DBIT: received word, LSB first on the line.
- `frame_err`, output, 1: stop bit sampled low for the last frame.
- `parity_err`, output, 1: parity mismatch for the last frame. Always 0 when `PARITY_EN` = 0.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. The FSM sees only the synchronized value `rx_s`.
- The baud generator is a mod-`CLK_DIV` counter. `tick` is high for one clk cycle when the count equals `CLK_DIV`-1. The counter then wraps to 0. It free-runs and is never resynchronized to frames.
- Internal registers:
  - `s`: 4-bit tick counter. It is 5 bits when `SB_TICK` > 16.
  - `n`: bit counter, width clog2(`DBIT`).
  - `b`: DBIT shift register, loaded with `{rx_s, b[DBIT-1:1]}`.
- FSM states:
  - IDLE: when `rx_s` = 0, go to START with `s` = 0. No tick is required.
  - START: on each tick `s`++. At `s` = 7 (mid start bit): if `rx_s` = 0, go to DATA with `s` = 0 and `n` = 0. If `rx_s` = 1, the start bit was a glitch: go to IDLE with no output.
  - DATA: on each tick `s`++. At `s` = 15, shift `rx_s` into `b` and set `s` = 0. If `n` = DBIT-1, go to PARITY when `PARITY_EN` = 1, otherwise to STOP. Otherwise `n`++.
  - PARITY: at `s` = 15, capture the parity bit and set `s` = 0, then go to STOP.
  - STOP: at `s` = `SB_TICK`-1, sample `rx_s` and go to IDLE. Assert completion for this frame.
- Completion:
  - `dout` ← `b`.
  - `frame_err` ← ~`rx_s`.
  - `parity_err` ← (^`b` ^ parity_bit ^ `PARITY_ODD`) when `PARITY_EN` = 1, else 0.
  - `rx_done_tick` ← 1 for one cycle.
- `rx_done_tick` pulses on every completed frame, including errored ones. Downstream decides whether to drop errored words.
- `dout`, `frame_err` and `parity_err` hold until the next completion.
- Break condition: `rx` is held low. It completes one frame with `frame_err` = 1 and `dout` = 0. The FSM then sits in IDLE → START → DATA again only after `rx_s` returns high and falls again. IDLE requires a 1 → 0 transition: IDLE is entered only from STOP with `rx_s` = 1, or on reset.

## Timing
- All outputs are registered.
- Reset values: `rx_done_tick` = 0, `dout` = 0, `frame_err` = 0, `parity_err` = 0. FSM = IDLE, baud counter = 0.
- Synchronizer latency is 2 clk cycles from `rx` to `rx_s`.
- `rx_done_tick`, `dout` and the error flags update in the clk cycle after the tick on which STOP reaches `s` = `SB_TICK`-1. `dout` is valid in the same cycle as the pulse.
- Frame length in ticks from the falling edge: 8 + 16·DBIT + 16·PARITY_EN + `SB_TICK`, with ±1 tick phase uncertainty.
- Back-to-back frames with zero idle are supported. The FSM is in IDLE and accepts the next start edge in the cycle after the STOP sample.
- Reset during any state forces IDLE immediately and discards partial data. No `rx_done_tick` is emitted for an aborted frame.
- The FIFO must accept one write per frame. Overflow is the FIFO's concern; this block never back-pressures.

## Structure
- Shared package `uart_pkg` holds the state encodings (IDLE, START, DATA, PARITY, STOP) and the `OVERSAMPLE` = 16 constant. The same package is reused by `uart_tx`.
- One sub-module, `baud_gen`, with parameter `CLK_DIV` and ports `clk`, `reset`, `tick`. The same instance type is reused by the transmitter.
- The synchronizer and FSM live in `uart_rx`.

## Test plan
All scenarios use `CLK_DIV` = 4, which gives 64 clk per bit.
- Reset, then `rx` = 1 for 2000 cycles → no `rx_done_tick`, all outputs 0.
- 8N1 frame carrying 0xA5 → exactly one pulse, `dout` = 0xA5, `frame_err` = 0, `parity_err` = 0.
- Frame 0x3C with the stop bit driven 0 → pulse, `dout` = 0x3C, `frame_err` = 1. A following good frame 0x01 → `dout` = 0x01, `frame_err` = 0.
- `rx` low for 20 clk (< 8 ticks), then high → no pulse, FSM back in IDLE. A following frame 0x55 is received correctly.
- With `PARITY_EN` = 1 and even parity, 0x07 sent with parity bit 0 → `parity_err` = 1. 0x07 sent with parity bit 1 → `parity_err` = 0.
- Reset asserted mid-DATA after 3 bits of 0xFF, then frames 0x11 and 0x22 sent back-to-back with no idle gap → no pulse for the aborted frame, then two pulses with `dout` = 0x11 then 0x22.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
// Both the receiver and the transmitter import this package.
package uart_pkg;

  // Ticks per bit period on the serial line.
  localparam int OVERSAMPLE = 16;

  // Tick count at which the start bit is checked (mid start bit).
  localparam int MID_TICK = OVERSAMPLE / 2 - 1;

  // Framing states shared by the receiver and the transmitter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/baud_gen.sv
// Free-running mod-CLK_DIV counter that produces a one-clk oversampling strobe.
// It is never resynchronised to frame boundaries.
module baud_gen #(
  parameter int CLK_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..CLK_DIV-1 and wrap; the strobe marks the terminal count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule : baud_gen

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling deframer for start/data/optional-parity/stop.
// Produces one registered word and a one-cycle done pulse per completed frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int CLK_DIV    = 163,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  // Tick counter needs a fifth bit only for stop periods longer than one bit.
  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          PAR_EN = (PARITY_EN != 0);
  localparam logic          ODD    = (PARITY_ODD != 0);

  logic            tick;
  logic [1:0]      sync_q;
  logic            rx_s;
  uart_state_e     state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            par_q;
  logic            brk_q;

  baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous line, resetting to the idle level.
  // NOTE: reset to 1 so the FSM never sees a false start edge coming out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // Deframing FSM with registered outputs; completion loads dout and error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      par_q        <= 1'b0;
      brk_q        <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (s_q == S_MID) begin
              s_q <= '0;
              n_q <= '0;
              // A line that is high again at mid start bit was only a glitch.
              state_q <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (s_q == S_BIT) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= PAR_EN ? ST_PARITY : ST_STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              par_q   <= rx_s;
              state_q <= ST_STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (brk_q) begin
            // Stop bit was low: hold here until the line returns high so that
            // IDLE only ever starts on a genuine 1 -> 0 transition.
            if (rx_s) begin
              brk_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (tick) begin
            if (s_q == S_STOP) begin
              s_q          <= '0;
              rx_done_tick <= 1'b1;
              dout         <= b_q;
              frame_err    <= ~rx_s;
              parity_err   <= PAR_EN ? ((^b_q) ^ par_q ^ ODD) : 1'b0;
              if (rx_s) begin
                state_q <= ST_IDLE;
              end else begin
                brk_q <= 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, CLK_DIV = 4
// (64 clk per bit). Received words are captured by negedge monitors.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       reset;
  logic       rx_a;
  logic       rx_b;
  logic       done_a;
  logic       done_b;
  logic [7:0] dout_a;
  logic [7:0] dout_b;
  logic       ferr_a;
  logic       ferr_b;
  logic       perr_a;
  logic       perr_b;

  int n_cmp;
  int n_bad;

  int         cnt_a;
  int         cnt_b;
  logic [7:0] q_a[$];

  uart_rx #(
    .DBIT(8), .SB_TICK(16), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_a),
    .rx_done_tick (done_a),
    .dout         (dout_a),
    .frame_err    (ferr_a),
    .parity_err   (perr_a)
  );

  uart_rx #(
    .DBIT(8), .SB_TICK(16), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_b),
    .rx_done_tick (done_b),
    .dout         (dout_b),
    .frame_err    (ferr_b),
    .parity_err   (perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses (one per high cycle) and record words away from the active edge.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      cnt_a = cnt_a + 1;
      q_a.push_back(dout_a);
    end
    if (done_b === 1'b1) begin
      cnt_b = cnt_b + 1;
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional parity, stop; line left high at the end.
  task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                            input logic par, input logic stop);
    drive(sel, 1'b0);
    idle(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      drive(sel, data[i]);
      idle(BIT_CLK);
    end
    if (par_en) begin
      drive(sel, par);
      idle(BIT_CLK);
    end
    drive(sel, stop);
    idle(BIT_CLK);
    drive(sel, 1'b1);
  endtask

  task automatic pop_a(output logic [7:0] w);
    if (q_a.size() != 0) w = q_a.pop_front();
    else                 w = 8'hxx;
  endtask

  task automatic test_reset;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    reset = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(2000);
    n_cmp++; if (cnt_a !== 0) begin n_bad++; $display("FAIL reset_pulses_a got=%0d exp=0", cnt_a); end
    n_cmp++; if (cnt_b !== 0) begin n_bad++; $display("FAIL reset_pulses_b got=%0d exp=0", cnt_b); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
    n_cmp++; if (dout_a !== 8'h00) begin n_bad++; $display("FAIL reset_dout got=%h exp=00", dout_a); end
    n_cmp++; if ({ferr_a, perr_a, ferr_b, perr_b} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=0000", {ferr_a, perr_a, ferr_b, perr_b});
    end
  endtask

  task automatic test_8n1;
    int base;
    logic [7:0] w;
    base = cnt_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(20);
    pop_a(w);
    n_cmp++; if (cnt_a - base !== 1) begin n_bad++; $display("FAIL a5_pulses got=%0d exp=1", cnt_a - base); end
    n_cmp++; if (w !== 8'hA5) begin n_bad++; $display("FAIL a5_word got=%h exp=a5", w); end
    n_cmp++; if ({ferr_a, perr_a} !== 2'b00) begin n_bad++; $display("FAIL a5_flags got=%b exp=00", {ferr_a, perr_a}); end
    idle(200);
    n_cmp++; if (dout_a !== 8'hA5) begin n_bad++; $display("FAIL a5_hold got=%h exp=a5", dout_a); end
    n_cmp++; if (cnt_a - base !== 1) begin n_bad++; $display("FAIL a5_idle_pulses got=%0d exp=1", cnt_a - base); end
  endtask

  task automatic test_frame_err;
    int base;
    logic [7:0] w;
    base = cnt_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(128);
    pop_a(w);
    n_cmp++; if (cnt_a - base !== 1) begin n_bad++; $display("FAIL ferr_pulses got=%0d exp=1", cnt_a - base); end
    n_cmp++; if (w !== 8'h3C) begin n_bad++; $display("FAIL ferr_word got=%h exp=3c", w); end
    n_cmp++; if (ferr_a !== 1'b1) begin n_bad++; $display("FAIL ferr_flag got=%b exp=1", ferr_a); end
    send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    idle(20);
    pop_a(w);
    n_cmp++; if (cnt_a - base !== 2) begin n_bad++; $display("FAIL ferr_next_pulses got=%0d exp=2", cnt_a - base); end
    n_cmp++; if (w !== 8'h01) begin n_bad++; $display("FAIL ferr_next_word got=%h exp=01", w); end
    n_cmp++; if (ferr_a !== 1'b0) begin n_bad++; $display("FAIL ferr_next_flag got=%b exp=0", ferr_a); end
  endtask

  task automatic test_glitch;
    int base;
    logic [7:0] w;
    base = cnt_a;
    rx_a = 1'b0;
    idle(20);
    rx_a = 1'b1;
    idle(200);
    n_cmp++; if (cnt_a - base !== 0) begin n_bad++; $display("FAIL glitch_pulses got=%0d exp=0", cnt_a - base); end
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    idle(20);
    pop_a(w);
    n_cmp++; if (cnt_a - base !== 1) begin n_bad++; $display("FAIL glitch_next_pulses got=%0d exp=1", cnt_a - base); end
    n_cmp++; if (w !== 8'h55) begin n_bad++; $display("FAIL glitch_next_word got=%h exp=55", w); end
  endtask

  task automatic test_parity;
    int base;
    base = cnt_b;
    // 0x07 has three ones: even parity requires a parity bit of 1.
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(20);
    n_cmp++; if (cnt_b - base !== 1) begin n_bad++; $display("FAIL par_bad_pulses got=%0d exp=1", cnt_b - base); end
    n_cmp++; if (dout_b !== 8'h07) begin n_bad++; $display("FAIL par_bad_word got=%h exp=07", dout_b); end
    n_cmp++; if ({perr_b, ferr_b} !== 2'b10) begin n_bad++; $display("FAIL par_bad_flags got=%b exp=10", {perr_b, ferr_b}); end
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    n_cmp++; if (cnt_b - base !== 2) begin n_bad++; $display("FAIL par_ok_pulses got=%0d exp=2", cnt_b - base); end
    n_cmp++; if (dout_b !== 8'h07) begin n_bad++; $display("FAIL par_ok_word got=%h exp=07", dout_b); end
    n_cmp++; if ({perr_b, ferr_b} !== 2'b00) begin n_bad++; $display("FAIL par_ok_flags got=%b exp=00", {perr_b, ferr_b}); end
    n_cmp++; if (perr_a !== 1'b0) begin n_bad++; $display("FAIL par_disabled got=%b exp=0", perr_a); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] w;
    base = cnt_a;
    // Start bit plus three data bits of 0xFF, then abort with reset mid-DATA.
    rx_a = 1'b0;
    idle(BIT_CLK);
    rx_a = 1'b1;
    idle(3 * BIT_CLK);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(10);
    n_cmp++; if (cnt_a - base !== 0) begin n_bad++; $display("FAIL abort_pulses got=%0d exp=0", cnt_a - base); end
    n_cmp++; if (dout_a !== 8'h00) begin n_bad++; $display("FAIL abort_dout got=%h exp=00", dout_a); end
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(20);
    n_cmp++; if (cnt_a - base !== 2) begin n_bad++; $display("FAIL b2b_pulses got=%0d exp=2", cnt_a - base); end
    pop_a(w);
    n_cmp++; if (w !== 8'h11) begin n_bad++; $display("FAIL b2b_first got=%h exp=11", w); end
    pop_a(w);
    n_cmp++; if (w !== 8'h22) begin n_bad++; $display("FAIL b2b_second got=%h exp=22", w); end
    n_cmp++; if (ferr_a !== 1'b0) begin n_bad++; $display("FAIL b2b_ferr got=%b exp=0", ferr_a); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cnt_a = 0;
    cnt_b = 0;
    test_reset();
    test_8n1();
    test_frame_err();
    test_glitch();
    test_parity();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rx
